// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, token lookup and the alignment state enum.
// Used by both the channel decoder and the transmit-side encoder.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic [9:0] ctrl_to_token(input logic [1:0] ctrl_bits);
    logic [9:0] tok;
    case (ctrl_bits)
      2'b00:   tok = TOKEN_C00;
      2'b01:   tok = TOKEN_C01;
      2'b10:   tok = TOKEN_C10;
      default: tok = TOKEN_C11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS word into token flag, control bits
// and pixel byte. Non-token words are always decoded as data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    is_token = 1'b0;
    ctrl     = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (sym == ctrl_to_token(2'(c))) begin
        is_token = 1'b1;
        ctrl     = 2'(c);
      end
    end
    // bit 9 flags inversion for DC balance, bit 8 selects XOR vs XNOR chaining
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment by control-token runs, then symbol decode.
// Define TMDS_STATS_EN to add the saturating relock_cnt lock-loss counter port.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN = 16,
  parameter int DWELL    = 1024
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] sym_in,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_STATS_EN
  ,
  output logic [7:0] relock_cnt
`endif
);

  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int DW = $clog2(DWELL);
  localparam logic [RW-1:0] RUN_FULL   = RW'(LOCK_RUN);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [19:0]   win_q, win_d;
  logic [3:0]    offset_q, offset_d;
  logic [RW-1:0] run_q, run_d, run_next;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    skip_q, skip_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          de_q, de_d;
  logic          locked_q, locked_d;

  logic [19:0]   win_shift;
  logic [9:0]    aligned;
  logic          dec_token;
  logic [1:0]    dec_ctrl;
  logic [7:0]    dec_data;
  logic          lock_hit;
  logic          dwell_end;

  assign win_shift = win_q >> offset_q;
  assign aligned   = win_shift[9:0];

  tmds_symbol_decode u_decode (
    .sym      (aligned),
    .is_token (dec_token),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  // Words seen within two cycles of an offset step straddle the old alignment, so skip_q masks them.
  always_comb begin
    win_d    = {sym_in, win_q[19:10]};
    run_next = '0;
    if (dec_token && skip_q == 2'd0) begin
      run_next = (run_q == RUN_FULL) ? RUN_FULL : run_q + RW'(1);
    end
    lock_hit  = (run_next == RUN_FULL);
    dwell_end = (dwell_q == DWELL_LAST);

    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_next;
    dwell_d  = dwell_q + DW'(1);
    skip_d   = (skip_q == 2'd0) ? 2'd0 : skip_q - 2'd1;

    if (lock_hit) begin
      state_d = LOCKED;
      dwell_d = '0;
    end else if (dwell_end) begin
      run_d   = '0;
      dwell_d = '0;
      if (state_q == SEARCH) begin
        offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        skip_d   = 2'd2;
      end else begin
        state_d = SEARCH;
      end
    end

    locked_d = (state_d == LOCKED);
    de_d     = locked_d && !dec_token;
    data_d   = de_d ? dec_data : '0;
    ctrl_d   = (locked_d && dec_token) ? dec_ctrl : '0;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q  <= SEARCH;
      win_q    <= '0;
      offset_q <= '0;
      run_q    <= '0;
      dwell_q  <= '0;
      skip_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      dwell_q  <= dwell_d;
      skip_q   <= skip_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign offset = offset_q;

`ifdef TMDS_STATS_EN
  logic [7:0] relock_q, relock_d;

  always_comb begin
    relock_d = relock_q;
    if (state_q == LOCKED && state_d == SEARCH && relock_q != 8'hFF) begin
      relock_d = relock_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
`endif

endmodule
